ff_loop_tester: RTL and testbench

Bit-serial traffic generator and checker for the EthernetModule FIFO-side (ff_*) interface, all in the ff_clk domain. The generator drives framed PRBS-7 traffic into the module's sink port. The checker consumes the module's source port, finds frame sync, verifies the payload bit by bit, and reports lock, frame and error counts. It lets a board test run end-to-end traffic across a real Ethernet link without a host.

---
 rtl/ff_loop_tester.sv | 173 +++++++++++++++++
 tb/tb_ff_loop_tester.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ff_loop_tester.sv
// rtl/ff_loop_tester.sv - PRBS-7 framed bit-serial generator and checker for the ff_* interface
module ff_loop_tester #(
  parameter logic [15:0] SYNC        = 16'hF0A5,
  parameter int          PAYLOAD_LEN = 496,
  parameter int          ERR_W       = 16,
  parameter int          FRM_W       = 16
) (
  input  logic             ff_clk,
  input  logic             reset,
  input  logic             gen_en,
  output logic             ff_en_sink,
  output logic             ff_data_sink,
  input  logic             ff_en_source,
  input  logic             ff_data_source,
  output logic             locked,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = $clog2(PAYLOAD_LEN > 16 ? PAYLOAD_LEN : 16);
  localparam logic [CW-1:0] LAST_BIT = CW'(PAYLOAD_LEN - 1);

  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  typedef enum logic [1:0] {G_IDLE, G_SYNC, G_PAY, G_GAP} gen_state_e;
  typedef enum logic       {C_HUNT, C_CHECK} chk_state_e;

  gen_state_e      gst_q, gst_d;
  logic [CW-1:0]   gcnt_q, gcnt_d;
  logic [6:0]      glfsr_q, glfsr_d;
  logic            gen_q, gen_d, gdat_q, gdat_d;

  chk_state_e      cst_q, cst_d;
  logic [15:0]     sh_q, sh_d;
  logic [6:0]      clfsr_q, clfsr_d;
  logic [CW-1:0]   ccnt_q, ccnt_d;
  logic            ferr_q, ferr_d;
  logic            lock_q, lock_d;
  logic            done_q, done_d;
  logic [FRM_W-1:0] fcnt_q, fcnt_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;

  logic [15:0]     hunt_word;
  logic            miss;

  // Outputs are registered from the next state, so the bit for a phase appears on the edge that enters it.
  always_comb begin
    gst_d   = gst_q;
    gcnt_d  = gcnt_q;
    glfsr_d = glfsr_q;
    case (gst_q)
      G_IDLE: if (gen_en) begin
        gst_d  = G_SYNC;
        gcnt_d = '0;
      end
      G_SYNC: if (gcnt_q == CW'(15)) begin
        gst_d   = G_PAY;
        gcnt_d  = '0;
        glfsr_d = 7'h7F;
      end else begin
        gcnt_d = gcnt_q + CW'(1);
      end
      G_PAY: begin
        glfsr_d = prbs_next(glfsr_q);
        if (gcnt_q == LAST_BIT) begin
          gst_d  = G_GAP;
          gcnt_d = '0;
        end else begin
          gcnt_d = gcnt_q + CW'(1);
        end
      end
      G_GAP: begin
        gcnt_d = '0;
        gst_d  = gen_en ? G_SYNC : G_IDLE;
      end
      default: gst_d = G_IDLE;
    endcase
    gen_d  = (gst_d == G_SYNC) || (gst_d == G_PAY);
    gdat_d = 1'b0;
    if (gst_d == G_SYNC)     gdat_d = SYNC[4'd15 - gcnt_d[3:0]];
    else if (gst_d == G_PAY) gdat_d = glfsr_d[6];
  end

  assign hunt_word = {sh_q[14:0], ff_data_source};
  assign miss      = ff_data_source ^ clfsr_q[6];

  always_comb begin
    cst_d   = cst_q;
    sh_d    = sh_q;
    clfsr_d = clfsr_q;
    ccnt_d  = ccnt_q;
    ferr_d  = ferr_q;
    lock_d  = lock_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    if (ff_en_source) begin
      case (cst_q)
        C_HUNT: begin
          sh_d = hunt_word;
          if (hunt_word == SYNC) begin
            cst_d   = C_CHECK;
            clfsr_d = 7'h7F;
            ccnt_d  = '0;
            ferr_d  = 1'b0;
          end
        end
        C_CHECK: begin
          clfsr_d = prbs_next(clfsr_q);
          if (miss) begin
            ferr_d = 1'b1;
            if (ecnt_q != '1) ecnt_d = ecnt_q + ERR_W'(1);
          end
          if (ccnt_q == LAST_BIT) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + FRM_W'(1);
            lock_d = !(ferr_q || miss);
            cst_d  = C_HUNT;
            sh_d   = '0;
          end else begin
            ccnt_d = ccnt_q + CW'(1);
          end
        end
        default: cst_d = C_HUNT;
      endcase
    end
  end

  always_ff @(posedge ff_clk or posedge reset) begin
    if (reset) begin
      gst_q   <= G_IDLE;
      gcnt_q  <= '0;
      glfsr_q <= '0;
      gen_q   <= 1'b0;
      gdat_q  <= 1'b0;
      cst_q   <= C_HUNT;
      sh_q    <= '0;
      clfsr_q <= '0;
      ccnt_q  <= '0;
      ferr_q  <= 1'b0;
      lock_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      gst_q   <= gst_d;
      gcnt_q  <= gcnt_d;
      glfsr_q <= glfsr_d;
      gen_q   <= gen_d;
      gdat_q  <= gdat_d;
      cst_q   <= cst_d;
      sh_q    <= sh_d;
      clfsr_q <= clfsr_d;
      ccnt_q  <= ccnt_d;
      ferr_q  <= ferr_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign ff_en_sink   = gen_q;
  assign ff_data_sink = gdat_q;
  assign locked       = lock_q;
  assign frame_done   = done_q;
  assign frame_cnt    = fcnt_q;
  assign err_cnt      = ecnt_q;

endmodule

// File: tb/tb_ff_loop_tester.sv
// tb/tb_ff_loop_tester.sv - directed loopback and checker-only bench for ff_loop_tester
module tb_ff_loop_tester;
  localparam int PL = 496;
  localparam logic [15:0] SYNC_W = 16'hF0A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, gen_en, loop, t_en, t_data;
  wire  sink_en, sink_data, src_en, src_data, locked, fdone;
  wire  [15:0] fcnt, ecnt;
  wire  sink_en2, sink_data2, locked2, fdone2;
  wire  [15:0] fcnt2;
  wire  [3:0]  ecnt2;

  assign src_en   = loop ? sink_en   : t_en;
  assign src_data = loop ? sink_data : t_data;

  ff_loop_tester dut (
    .ff_clk(clk), .reset(rst), .gen_en(gen_en),
    .ff_en_sink(sink_en), .ff_data_sink(sink_data),
    .ff_en_source(src_en), .ff_data_source(src_data),
    .locked(locked), .frame_done(fdone), .frame_cnt(fcnt), .err_cnt(ecnt)
  );

  ff_loop_tester #(.ERR_W(4)) dut_sat (
    .ff_clk(clk), .reset(rst), .gen_en(1'b0),
    .ff_en_sink(sink_en2), .ff_data_sink(sink_data2),
    .ff_en_source(src_en), .ff_data_source(src_data),
    .locked(locked2), .frame_done(fdone2), .frame_cnt(fcnt2), .err_cnt(ecnt2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fd_count = 0;
  int fd_cyc [8];
  logic fd_locked [8];
  logic pr [PL];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fdone) begin
      fd_cyc[fd_count % 8]    <= cyc;
      fd_locked[fd_count % 8] <= locked;
      fd_count                <= fd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; gen_en = 1'b0; loop = 1'b0; t_en = 1'b0; t_data = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_fd(input int target, input int limit, input string tag);
    int n = 0;
    while (fd_count < target && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(fd_count >= target), 1);
  endtask

  // Stalled bits are followed by an idle cycle carrying the inverted value.
  task automatic send_frame(input logic [15:0] sw, input int err_pos, input logic inv,
                            input logic stall, input logic exp_done, input string tag);
    logic b;
    for (int i = 15; i >= 0; i--) begin
      t_en = 1'b1; t_data = sw[i]; tick();
      if (stall) begin t_en = 1'b0; t_data = ~sw[i]; tick(); end
    end
    for (int k = 0; k < PL; k++) begin
      b = pr[k] ^ inv ^ (k == err_pos);
      t_en = 1'b1; t_data = b; tick();
      if (k == PL - 1) check(tag, 32'(fdone), 32'(exp_done));
      if (stall) begin t_en = 1'b0; t_data = ~b; tick(); end
    end
    t_en = 1'b0; t_data = 1'b0; tick();
  endtask

  int start, base;

  initial begin
    for (int k = 0; k < PL; k++) pr[k] = (k < 7) ? 1'b1 : (pr[k-7] ^ pr[k-6]);

    rst = 1'b1; gen_en = 1'b0; loop = 1'b0; t_en = 1'b0; t_data = 1'b0;
    tick();
    check("rst_sink_en", 32'(sink_en), 0);
    check("rst_sink_data", 32'(sink_data), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_frame_done", 32'(fdone), 0);
    check("rst_frame_cnt", 32'(fcnt), 0);
    check("rst_err_cnt", 32'(ecnt), 0);

    // Loopback, three frames
    rst = 1'b0; tick();
    loop = 1'b1; gen_en = 1'b1;
    start = cyc; base = fd_count;
    wait_fd(base + 2, 1200, "loop_two_frames");
    gen_en = 1'b0;
    wait_fd(base + 3, 700, "loop_third_frame");
    repeat (600) tick();
    check("loop_pulses", 32'(fd_count - base), 3);
    check("loop_first_latency", 32'(fd_cyc[base % 8] - start), 513);
    check("loop_period_1", 32'(fd_cyc[(base + 1) % 8] - fd_cyc[base % 8]), 513);
    check("loop_period_2", 32'(fd_cyc[(base + 2) % 8] - fd_cyc[(base + 1) % 8]), 513);
    check("loop_locked_first", 32'(fd_locked[base % 8]), 1);
    check("loop_frame_cnt", 32'(fcnt), 3);
    check("loop_err_cnt", 32'(ecnt), 0);
    check("loop_locked", 32'(locked), 1);
    check("loop_gen_idle", 32'(sink_en), 0);

    // Single payload bit error in frame 2
    do_reset();
    send_frame(SYNC_W, -1, 1'b0, 1'b0, 1'b1, "err_f1_done");
    check("err_f1_lock", 32'(locked), 1);
    send_frame(SYNC_W, 10, 1'b0, 1'b0, 1'b1, "err_f2_done");
    check("err_f2_cnt", 32'(ecnt), 1);
    check("err_f2_lock", 32'(locked), 0);
    send_frame(SYNC_W, -1, 1'b0, 1'b0, 1'b1, "err_f3_done");
    check("err_f3_lock", 32'(locked), 1);
    check("err_f3_frames", 32'(fcnt), 3);
    check("err_f3_cnt", 32'(ecnt), 1);

    // Stalled bits
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(SYNC_W, -1, 1'b0, 1'b1, 1'b1, "stall_done");
    check("stall_frames", 32'(fcnt), 3);
    check("stall_err", 32'(ecnt), 0);
    check("stall_lock", 32'(locked), 1);

    // Corrupted sync, then clean frame
    do_reset();
    send_frame(SYNC_W ^ 16'h0008, -1, 1'b0, 1'b0, 1'b0, "badsync_no_done");
    send_frame(SYNC_W, -1, 1'b0, 1'b0, 1'b1, "badsync_clean_done");
    check("badsync_frames", 32'(fcnt), 1);
    check("badsync_err", 32'(ecnt), 0);

    // Fully inverted payloads: 4-bit counter saturates, 16-bit counts all
    do_reset();
    send_frame(SYNC_W, -1, 1'b1, 1'b0, 1'b1, "inv_f1_done");
    send_frame(SYNC_W, -1, 1'b1, 1'b0, 1'b1, "inv_f2_done");
    check("sat_err_cnt", 32'(ecnt2), 15);
    check("sat_locked", 32'(locked2), 0);
    check("sat_frames", 32'(fcnt2), 2);
    check("sat_done_idle", 32'(fdone2), 0);
    check("sat_gen_off", 32'({sink_en2, sink_data2}), 0);
    check("inv_err_cnt", 32'(ecnt), 992);
    check("inv_locked", 32'(locked), 0);

    // Asynchronous reset mid-payload of frame 2
    do_reset();
    loop = 1'b1; gen_en = 1'b1;
    base = fd_count;
    wait_fd(base + 1, 700, "mid_first_frame");
    repeat (200) tick();
    check("mid_gen_active", 32'(sink_en), 1);
    check("mid_frame_cnt_pre", 32'(fcnt), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sink_en", 32'(sink_en), 0);
    check("mid_rst_frame_cnt", 32'(fcnt), 0);
    check("mid_rst_locked", 32'(locked), 0);
    tick();
    rst = 1'b0;
    base = fd_count;
    wait_fd(base + 1, 700, "mid_restart_frame");
    gen_en = 1'b0;
    check("mid_frame_cnt", 32'(fcnt), 1);
    check("mid_locked", 32'(locked), 1);
    check("mid_err_cnt", 32'(ecnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
